// File: rtl/lx32_mem_pkg.sv
// rtl/lx32_mem_pkg.sv - shared types and constants for the lx32 memory arbiter
package lx32_mem_pkg;

  localparam int XLEN           = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request channels and single-port RAM bus
interface mem_arbiter_if import lx32_mem_pkg::*; #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [XLEN-1:0]       if_addr;
  logic                  if_rsp_valid;
  logic [XLEN-1:0]       if_rdata;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic [XLEN-1:0]       d_addr;
  logic                  d_we;
  logic [3:0]            d_be;
  logic [XLEN-1:0]       d_wdata;
  logic                  d_rsp_valid;
  logic [XLEN-1:0]       d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [XLEN-1:0]       mem_wdata;
  logic [XLEN-1:0]       mem_rdata;

  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_be, d_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rdata, d_req_ready, d_rsp_valid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_be, d_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rdata, d_req_ready, d_rsp_valid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - data-over-fetch grant selection with bounded fetch starvation
module mem_arb_sel import lx32_mem_pkg::*; #(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved  = (starve_cnt == CW'(STARVE_MAX));
  assign grant_d  = grant_en && d_valid && !(if_valid && starved);
  assign grant_if = grant_en && if_valid && (!d_valid || starved);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && if_valid) begin
      if (!starved) starve_cnt <= starve_cnt + CW'(1);
    end else if (grant_en && !if_valid) begin
      starve_cnt <= '0;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter onto a single-port RAM, fixed latency 2
module mem_arbiter import lx32_mem_pkg::*; #(
  parameter int DEPTH_LOG2 = 10,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  mem_state_t            state_q;
  logic                  first_q;
  logic                  owner_d_q;
  logic                  rd_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [3:0]            mem_be_q;
  logic [DEPTH_LOG2-1:0] mem_addr_q;
  logic [XLEN-1:0]       mem_wdata_q;
  logic                  if_rsp_q;
  logic                  d_rsp_q;
  logic                  grant_en;
  logic                  grant_if;
  logic                  grant_d;

  // The cycle right after reset is kept quiet, so no grant until first_q drops.
  assign grant_en = (state_q == IDLE) && !rst && !first_q;

  mem_arb_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .clk      (clk),
    .rst      (rst),
    .grant_en (grant_en),
    .if_valid (bus.if_req_valid),
    .d_valid  (bus.d_req_valid),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      first_q     <= 1'b1;
      owner_d_q   <= 1'b0;
      rd_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rsp_q    <= 1'b0;
      d_rsp_q     <= 1'b0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_d_q   <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_be_q    <= bus.d_be;
            mem_addr_q  <= bus.d_addr[DEPTH_LOG2+1:2];
            mem_wdata_q <= bus.d_wdata;
            state_q     <= ACCESS;
          end else if (grant_if) begin
            owner_d_q   <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= bus.if_addr[DEPTH_LOG2+1:2];
            mem_wdata_q <= '0;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_be_q    <= '0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          rd_q        <= ~mem_we_q;
          if_rsp_q    <= ~owner_d_q;
          d_rsp_q     <= owner_d_q;
          state_q     <= RESP;
        end
        RESP: begin
          if_rsp_q <= 1'b0;
          d_rsp_q  <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with rst keeps an aborted access from reaching the RAM on the reset edge.
  assign bus.mem_en       = mem_en_q & ~rst;
  assign bus.mem_we       = mem_we_q & ~rst;
  assign bus.mem_be       = rst ? 4'b0000 : mem_be_q;
  assign bus.mem_addr     = rst ? '0 : mem_addr_q;
  assign bus.mem_wdata    = rst ? '0 : mem_wdata_q;

  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;
  assign bus.if_rsp_valid = if_rsp_q & ~rst;
  assign bus.d_rsp_valid  = d_rsp_q & ~rst;
  assign bus.if_rdata     = (bus.if_rsp_valid && rd_q) ? bus.mem_rdata : '0;
  assign bus.d_rdata      = (bus.d_rsp_valid && rd_q) ? bus.mem_rdata : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[XLEN-1:DEPTH_LOG2+2], bus.if_addr[1:0],
                              bus.d_addr[XLEN-1:DEPTH_LOG2+2], bus.d_addr[1:0]};
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive data grants while a fetch is pending.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports if_req_valid in 1, if_req_ready out 1, if_addr in 32: fetch request channel.
REQ-006 SHALL have ports if_rsp_valid out 1, if_rdata out 32: fetch response channel.
REQ-007 SHALL have ports d_req_valid in 1, d_req_ready out 1, d_addr in 32, d_we in 1, d_be in 4, d_wdata in 32: data request channel.
REQ-008 SHALL have ports d_rsp_valid out 1, d_rdata out 32: data response channel.
REQ-009 SHALL have ports mem_en out 1, mem_we out 1, mem_be out 4, mem_addr out DEPTH_LOG2, mem_wdata out 32, mem_rdata in 32: single-port synchronous RAM with 1-cycle read latency.

Function
REQ-010 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, with at most one request in flight.
REQ-011 SHALL assert a req_ready only in IDLE and only for the granted side; ready may depend on valid, valid never depends on ready.
REQ-012 SHALL transfer a request when valid&&ready in cycle N, register its fields, and move to ACCESS.
REQ-013 SHALL drive mem_en=1 in ACCESS (cycle N+1) with the registered address/we/be/wdata; mem_en=0 in all other states.
REQ-014 SHALL pulse the owner's rsp_valid for exactly one cycle in RESP (cycle N+2), with rdata=mem_rdata for reads and rdata=0 for writes; fixed latency 2.
REQ-015 SHALL hold if_rdata/d_rdata at 0 whenever the corresponding rsp_valid=0.
REQ-016 SHALL drive mem_addr = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored; upper bits discarded (wrap modulo depth).
REQ-017 SHALL force mem_we=0 and mem_be=4'b0000 for fetch accesses.
REQ-018 SHALL grant data over fetch when both valid, unless starve_cnt==STARVE_MAX, in which case fetch is granted.
REQ-019 SHALL increment starve_cnt on each data grant made while if_req_valid=1, saturating at STARVE_MAX.
REQ-020 SHALL clear starve_cnt on a fetch grant or any IDLE cycle with if_req_valid=0.
REQ-021 SHALL apply no back-pressure on responses; requesters must sample rsp in the RESP cycle.
REQ-022 SHALL make requests arriving during ACCESS/RESP wait, with ready=0; requesters hold valid and fields stable until ready.
REQ-023 SHALL re-arbitrate on the next IDLE cycle with a fresh priority decision (no grant latched ahead).

Reset
REQ-024 SHALL on rst=1 at a clock edge enter IDLE, clear starve_cnt, and clear registered request fields.
REQ-025 SHALL hold all outputs 0 during reset and on the first cycle after it: readys, rsp_valids, rdatas, mem_*.
REQ-026 SHALL on reset mid-operation abort the in-flight request, issue no mem_en/write, and emit no response.

Structure
REQ-027 SHALL place the FSM state enum (IDLE/ACCESS/RESP), the default STARVE_MAX, and XLEN=32 in shared package lx32_mem_pkg.
REQ-028 SHALL place grant selection and starve_cnt in one sub-module, mem_arb_sel; the FSM and datapath registers stay in mem_arbiter.

Verification
REQ-029 SHALL verify single fetch: if_addr=0x0000_0010, RAM[4]=0xDEAD_BEEF -> mem_en at N+1, mem_addr=4; if_rsp_valid at N+2 with if_rdata=0xDEAD_BEEF.
REQ-030 SHALL verify write-then-read: d_we=1, d_be=4'b0011, d_addr=0x20, d_wdata=0x1234_5678 over old 0xFFFF_FFFF, then read 0x20 -> write d_rsp_valid with d_rdata=0; read returns 0xFFFF_5678.
REQ-031 SHALL verify simultaneous requests: both valid in IDLE -> d_req_ready=1, if_req_ready=0; fetch granted in the following IDLE once data drops.
REQ-032 SHALL verify starvation: data valid continuously with fetch pending, STARVE_MAX=4 -> 4 data grants, then 1 fetch grant, then data resumes.
REQ-033 SHALL verify wrap/misalignment: d_addr=0x0000_1013 -> mem_addr=0x004.
REQ-034 SHALL verify reset mid-operation: rst=1 in ACCESS of a write -> no d_rsp_valid, IDLE next cycle, all outputs 0.
